// File: rtl/fpu_norm_arb_if.sv
// Bundle of the request, shifter and response signals around the shared
// normalization shifter; the slave modport is the arbiter's view.
interface fpu_norm_arb_if #(
  parameter int TAG_W = 4
);
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [48:0]      req0_sum;
  logic [48:0]      req1_sum;
  logic [5:0]       req0_lza;
  logic [5:0]       req1_lza;
  logic [8:0]       req0_exp;
  logic [8:0]       req1_exp;
  logic             req0_sub;
  logic             req1_sub;
  logic [TAG_W-1:0] req0_tag;
  logic [TAG_W-1:0] req1_tag;
  logic [48:0]      sh_sum;
  logic [5:0]       sh_lza;
  logic [8:0]       sh_exp;
  logic             sh_sub;
  logic [47:0]      sh_shifted;
  logic [8:0]       sh_norm_exp;
  logic             sh_ovf;
  logic             sh_unf;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_src;
  logic [TAG_W-1:0] rsp_tag;
  logic [47:0]      rsp_sum;
  logic [8:0]       rsp_exp;
  logic             rsp_ovf;
  logic             rsp_unf;
  logic             busy;

  modport slave (
    input  req_valid, req0_sum, req1_sum, req0_lza, req1_lza, req0_exp, req1_exp,
           req0_sub, req1_sub, req0_tag, req1_tag,
           sh_shifted, sh_norm_exp, sh_ovf, sh_unf, rsp_ready,
    output req_ready, sh_sum, sh_lza, sh_exp, sh_sub,
           rsp_valid, rsp_src, rsp_tag, rsp_sum, rsp_exp, rsp_ovf, rsp_unf, busy
  );

  modport master (
    output req_valid, req0_sum, req1_sum, req0_lza, req1_lza, req0_exp, req1_exp,
           req0_sub, req1_sub, req0_tag, req1_tag,
           sh_shifted, sh_norm_exp, sh_ovf, sh_unf, rsp_ready,
    input  req_ready, sh_sum, sh_lza, sh_exp, sh_sub,
           rsp_valid, rsp_src, rsp_tag, rsp_sum, rsp_exp, rsp_ovf, rsp_unf, busy
  );
endinterface

// File: rtl/fpu_norm_arb.sv
// Two-port arbiter and two-stage sequencer for the shared FPU normalization shifter.
// Define FPU_NORM_ARB_RR_EN for round-robin arbitration; default is fixed priority to port 0.
module fpu_norm_arb #(
  parameter int TAG_W = 4
) (
  input logic          clk,
  input logic          rst_n,
  fpu_norm_arb_if.slave bus
);

  logic             s1_v_r;
  logic             s1_src_r;
  logic [TAG_W-1:0] s1_tag_r;
  logic [48:0]      sh_sum_r;
  logic [5:0]       sh_lza_r;
  logic [8:0]       sh_exp_r;
  logic             sh_sub_r;
  logic             s2_v_r;
  logic             s2_src_r;
  logic [TAG_W-1:0] s2_tag_r;
  logic [47:0]      rsp_sum_r;
  logic [8:0]       rsp_exp_r;
  logic             rsp_ovf_r;
  logic             rsp_unf_r;

  logic             s1_adv_s;
  logic             s2_adv_s;
  logic [1:0]       grant_s;
  logic             gnt_src_s;
  logic             take_s;
  logic             pref_s;
  logic [48:0]      in_sum_s;
  logic [5:0]       in_lza_s;
  logic [8:0]       in_exp_s;
  logic             in_sub_s;
  logic [TAG_W-1:0] in_tag_s;

  assign s2_adv_s  = ~s2_v_r | bus.rsp_ready;
  assign s1_adv_s  = ~s1_v_r | s2_adv_s;
  assign gnt_src_s = grant_s[1];
  assign take_s    = s1_adv_s & (|grant_s);

`ifdef FPU_NORM_ARB_RR_EN
  logic ptr_r;

  // Preference pointer: after a grant to port i, port ~i is preferred next.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= 1'b0;
    end else if (take_s) begin
      ptr_r <= ~gnt_src_s;
    end else begin
      ptr_r <= ptr_r;
    end
  end

  assign pref_s = ptr_r;
`else
  assign pref_s = 1'b0;
`endif

  // Grant selection from the valid vector and the current preference.
  always_comb begin
    grant_s = 2'b00;
    case (bus.req_valid)
      2'b01:   grant_s = 2'b01;
      2'b10:   grant_s = 2'b10;
      2'b11:   grant_s = pref_s ? 2'b10 : 2'b01;
      default: grant_s = 2'b00;
    endcase
  end

  // Payload mux for the granted port.
  always_comb begin
    in_sum_s = bus.req0_sum;
    in_lza_s = bus.req0_lza;
    in_exp_s = bus.req0_exp;
    in_sub_s = bus.req0_sub;
    in_tag_s = bus.req0_tag;
    if (gnt_src_s) begin
      in_sum_s = bus.req1_sum;
      in_lza_s = bus.req1_lza;
      in_exp_s = bus.req1_exp;
      in_sub_s = bus.req1_sub;
      in_tag_s = bus.req1_tag;
    end else begin
      in_sum_s = bus.req0_sum;
    end
  end

  // Issue stage: operands here feed the shifter directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_r   <= 1'b0;
      s1_src_r <= 1'b0;
      s1_tag_r <= '0;
      sh_sum_r <= 49'd0;
      sh_lza_r <= 6'd0;
      sh_exp_r <= 9'd0;
      sh_sub_r <= 1'b0;
    end else if (s1_adv_s) begin
      s1_v_r <= take_s;
      if (take_s) begin
        s1_src_r <= gnt_src_s;
        s1_tag_r <= in_tag_s;
        sh_sum_r <= in_sum_s;
        sh_lza_r <= in_lza_s;
        sh_exp_r <= in_exp_s;
        sh_sub_r <= in_sub_s;
      end
    end
  end

  // Result stage: payload only moves on advance so it holds under back-pressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v_r    <= 1'b0;
      s2_src_r  <= 1'b0;
      s2_tag_r  <= '0;
      rsp_sum_r <= 48'd0;
      rsp_exp_r <= 9'd0;
      rsp_ovf_r <= 1'b0;
      rsp_unf_r <= 1'b0;
    end else if (s2_adv_s) begin
      s2_v_r <= s1_v_r;
      if (s1_v_r) begin
        s2_src_r  <= s1_src_r;
        s2_tag_r  <= s1_tag_r;
        rsp_sum_r <= bus.sh_shifted;
        rsp_exp_r <= bus.sh_norm_exp;
        rsp_ovf_r <= bus.sh_ovf;
        rsp_unf_r <= bus.sh_unf;
      end
    end
  end

  assign bus.req_ready = grant_s & {2{s1_adv_s}};
  assign bus.sh_sum    = sh_sum_r;
  assign bus.sh_lza    = sh_lza_r;
  assign bus.sh_exp    = sh_exp_r;
  assign bus.sh_sub    = sh_sub_r;
  assign bus.rsp_valid = s2_v_r;
  assign bus.rsp_src   = s2_src_r;
  assign bus.rsp_tag   = s2_tag_r;
  assign bus.rsp_sum   = rsp_sum_r;
  assign bus.rsp_exp   = rsp_exp_r;
  assign bus.rsp_ovf   = rsp_ovf_r;
  assign bus.rsp_unf   = rsp_unf_r;
  assign bus.busy      = s1_v_r | s2_v_r;

endmodule

// File: tb/tb_fpu_norm_arb.sv
// Self-checking bench for fpu_norm_arb: directed scenarios plus random traffic
// against a queue-based reference of accepted jobs and a behavioural shifter.
module tb_fpu_norm_arb;

`ifdef FPU_NORM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct {
    logic [48:0] sum;
    logic [5:0]  lza;
    logic [8:0]  exp;
    logic        sub;
    logic [3:0]  tag;
    logic        src;
    int          acc;
  } job_t;

  logic clk;
  logic rst_n;
  fpu_norm_arb_if #(.TAG_W(4)) bus();

  fpu_norm_arb #(.TAG_W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  job_t pq0[$];
  job_t pq1[$];
  job_t sb[$];
  int   cyc, n_assert, n_fail, n_acc, n_rsp, seq_next;
  bit   pref, lat_chk, seq_chk, p1_chk;
  logic        snap_valid;
  logic [1:0]  snap_ready;
  logic [3:0]  snap_tag, r_tag;
  logic [47:0] snap_sum, r_sum;
  logic [8:0]  r_exp;
  logic        r_src, r_ovf, r_unf;

  // Behavioural shifter: carry-out shifts right by one, else left by the LZA count.
  function automatic void shift_ref(input logic [48:0] sum, input logic [5:0] lza,
                                    input logic [8:0] ex, output logic [47:0] shifted,
                                    output logic [8:0] nexp, output logic ovf, output logic unf);
    logic [48:0] t;
    int e;
    if (sum[48]) begin
      shifted = sum[48:1];
      e = int'(ex) + 1;
    end else begin
      t = sum << lza;
      shifted = t[47:0];
      e = int'(ex) - int'(lza);
    end
    unf = (e <= 0);
    ovf = (e >= 255);
    nexp = unf ? 9'd0 : (ovf ? 9'd255 : 9'(e));
  endfunction

  always_comb begin
    shift_ref(bus.sh_sum, bus.sh_lza, bus.sh_exp, bus.sh_shifted, bus.sh_norm_exp,
              bus.sh_ovf, bus.sh_unf);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic job_t mk(input logic src, input logic [3:0] tag, input logic [48:0] sum,
                              input logic [5:0] lza, input logic [8:0] ex, input logic sub);
    job_t j;
    j.src = src; j.tag = tag; j.sum = sum; j.lza = lza; j.exp = ex; j.sub = sub; j.acc = 0;
    return j;
  endfunction

  function automatic job_t rnd_job(input logic src);
    logic [48:0] s;
    s = {17'($urandom), $urandom};
    return mk(src, 4'($urandom), s, 6'($urandom_range(0, 47)), 9'($urandom), 1'($urandom));
  endfunction

  task automatic drive();
    bus.req_valid = {pq1.size() != 0, pq0.size() != 0};
    if (pq0.size() != 0) begin
      bus.req0_sum = pq0[0].sum; bus.req0_lza = pq0[0].lza; bus.req0_exp = pq0[0].exp;
      bus.req0_sub = pq0[0].sub; bus.req0_tag = pq0[0].tag;
    end else begin
      bus.req0_sum = 49'd0; bus.req0_lza = 6'd0; bus.req0_exp = 9'd0;
      bus.req0_sub = 1'b0; bus.req0_tag = 4'd0;
    end
    if (pq1.size() != 0) begin
      bus.req1_sum = pq1[0].sum; bus.req1_lza = pq1[0].lza; bus.req1_exp = pq1[0].exp;
      bus.req1_sub = pq1[0].sub; bus.req1_tag = pq1[0].tag;
    end else begin
      bus.req1_sum = 49'd0; bus.req1_lza = 6'd0; bus.req1_exp = 9'd0;
      bus.req1_sub = 1'b0; bus.req1_tag = 4'd0;
    end
  endtask

  // One cycle: drive at the falling edge, observe handshakes, then cross the rising edge.
  task automatic step();
    job_t j;
    logic [47:0] es;
    logic [8:0]  ee;
    logic        eo, eu;
    logic [1:0]  acc;
    drive();
    #1;
    acc = bus.req_valid & bus.req_ready;
    chk("ready_onehot", 64'($countones(bus.req_ready) <= 1), 64'd1);
    if (p1_chk && pq0.size() != 0) chk("p1_blocked", 64'(bus.req_ready[1]), 64'd0);
    if (bus.req_valid == 2'b11 && acc != 2'b00)
      chk("grant_pref", 64'(acc[1]), RR ? 64'(pref) : 64'd0);
    if (acc[0]) begin
      j = pq0.pop_front(); j.acc = cyc; sb.push_back(j); n_acc++; pref = 1'b1;
    end
    if (acc[1]) begin
      j = pq1.pop_front(); j.acc = cyc; sb.push_back(j); n_acc++; pref = 1'b0;
    end
    snap_valid = bus.rsp_valid;
    snap_ready = bus.req_ready;
    snap_tag   = bus.rsp_tag;
    snap_sum   = bus.rsp_sum;
    if (bus.rsp_valid && bus.rsp_ready) begin
      if (sb.size() == 0) begin
        chk("rsp_spurious", 64'd1, 64'd0);
      end else begin
        j = sb.pop_front();
        shift_ref(j.sum, j.lza, j.exp, es, ee, eo, eu);
        chk("rsp_src", 64'(bus.rsp_src), 64'(j.src));
        chk("rsp_tag", 64'(bus.rsp_tag), 64'(j.tag));
        chk("rsp_sum", 64'(bus.rsp_sum), 64'(es));
        chk("rsp_exp", 64'(bus.rsp_exp), 64'(ee));
        chk("rsp_ovf", 64'(bus.rsp_ovf), 64'(eo));
        chk("rsp_unf", 64'(bus.rsp_unf), 64'(eu));
        if (lat_chk) chk("latency", 64'(cyc - j.acc), 64'd2);
        if (seq_chk) begin
          chk("order_tag", 64'(bus.rsp_tag), 64'(seq_next));
          seq_next++;
        end
        r_tag = bus.rsp_tag; r_sum = bus.rsp_sum; r_exp = bus.rsp_exp;
        r_src = bus.rsp_src; r_ovf = bus.rsp_ovf; r_unf = bus.rsp_unf;
        n_rsp++;
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    pq0.delete(); pq1.delete(); sb.delete();
    pref = 1'b0;
    bus.rsp_ready = 1'b1;
    drive();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain(input string tag);
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 200 && (sb.size() != 0 || pq0.size() != 0 || pq1.size() != 0); k++) step();
    chk(tag, 64'(sb.size() + pq0.size() + pq1.size()), 64'd0);
  endtask

  initial begin
    int a0, r0;
    cyc = 0; n_assert = 0; n_fail = 0; n_acc = 0; n_rsp = 0;
    lat_chk = 1'b0; seq_chk = 1'b0; p1_chk = 1'b0; seq_next = 0;
    do_reset();
    #1;
    chk("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_sh_sum", 64'(bus.sh_sum), 64'd0);
    chk("reset_rsp_sum", 64'(bus.rsp_sum), 64'd0);
    @(negedge clk);

    // Single job with carry-out.
    lat_chk = 1'b1;
    r0 = n_rsp;
    pq0.push_back(mk(1'b0, 4'd3, 49'h1_0000_0000_0000, 6'd0, 9'd130, 1'b0));
    repeat (3) step();
    chk("single_count", 64'(n_rsp - r0), 64'd1);
    chk("single_src", 64'(r_src), 64'd0);
    chk("single_tag", 64'(r_tag), 64'd3);
    chk("single_exp", 64'(r_exp), 64'd131);
    chk("single_sum", 64'(r_sum), 64'h8000_0000_0000);

    // Contention.
    do_reset();
    seq_chk = 1'b1; seq_next = 0; r0 = n_rsp;
    if (RR) begin
      for (int i = 0; i < 6; i++) begin
        pq0.push_back(rnd_job(1'b0)); pq0[i].tag = 4'(2 * i);
        pq1.push_back(rnd_job(1'b1)); pq1[i].tag = 4'(2 * i + 1);
      end
      repeat (14) step();
      chk("rr_count", 64'(n_rsp - r0), 64'd12);
    end else begin
      p1_chk = 1'b1;
      for (int i = 0; i < 4; i++) begin
        pq0.push_back(rnd_job(1'b0)); pq0[i].tag = 4'(i);
      end
      for (int i = 0; i < 2; i++) begin
        pq1.push_back(rnd_job(1'b1)); pq1[i].tag = 4'(4 + i);
      end
      repeat (8) step();
      chk("fixed_count", 64'(n_rsp - r0), 64'd6);
    end
    seq_chk = 1'b0; p1_chk = 1'b0;
    drain("contention_drain");

    // Back-pressure.
    do_reset();
    lat_chk = 1'b0;
    for (int i = 0; i < 5; i++) pq0.push_back(rnd_job(1'b0));
    bus.rsp_ready = 1'b0;
    a0 = n_acc;
    step(); step(); step();
    chk("bp_ready_c2", 64'(snap_ready), 64'd0);
    chk("bp_valid_c2", 64'(snap_valid), 64'd1);
    r_tag = snap_tag; r_sum = snap_sum;
    step();
    chk("bp_ready_c3", 64'(snap_ready), 64'd0);
    chk("bp_hold_tag", 64'(snap_tag), 64'(r_tag));
    chk("bp_hold_sum", 64'(snap_sum), 64'(r_sum));
    chk("bp_accepts", 64'(n_acc - a0), 64'd2);
    bus.rsp_ready = 1'b1;
    r0 = n_rsp;
    repeat (5) step();
    chk("bp_release_count", 64'(n_rsp - r0), 64'd5);
    chk("bp_sb_empty", 64'(sb.size() + pq0.size()), 64'd0);

    // Asynchronous reset with both stages full.
    do_reset();
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) pq0.push_back(rnd_job(1'b0));
    pq0[0].sum = 49'h0_0000_0000_FFFF; pq0[0].lza = 6'd4; pq0[0].exp = 9'd100;
    repeat (3) step();
    chk("ar_busy_before", 64'(bus.busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("ar_busy", 64'(bus.busy), 64'd0);
    chk("ar_sh", 64'({bus.sh_lza, bus.sh_exp, bus.sh_sub}) | 64'(bus.sh_sum), 64'd0);
    chk("ar_rsp", 64'(bus.rsp_sum) | 64'({bus.rsp_tag, bus.rsp_exp, bus.rsp_src, bus.rsp_ovf, bus.rsp_unf}), 64'd0);
    pq0.delete(); sb.delete(); pref = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    lat_chk = 1'b1;
    r0 = n_rsp;
    pq1.push_back(rnd_job(1'b1));
    repeat (3) step();
    chk("ar_fresh_count", 64'(n_rsp - r0), 64'd1);

    // Underflow passthrough.
    r0 = n_rsp;
    pq1.push_back(mk(1'b1, 4'd9, 49'h0_0000_00FF_FFFF, 6'd40, 9'd20, 1'b1));
    repeat (3) step();
    chk("unf_count", 64'(n_rsp - r0), 64'd1);
    chk("unf_flag", 64'(r_unf), 64'd1);
    chk("unf_ovf", 64'(r_ovf), 64'd0);
    chk("unf_tag", 64'(r_tag), 64'd9);

    // Random traffic with random back-pressure.
    do_reset();
    lat_chk = 1'b0;
    a0 = n_acc; r0 = n_rsp;
    for (int k = 0; k < 80; k++) begin
      if ($urandom_range(0, 2) == 0 && pq0.size() < 3) pq0.push_back(rnd_job(1'b0));
      if ($urandom_range(0, 2) == 0 && pq1.size() < 3) pq1.push_back(rnd_job(1'b1));
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    drain("random_drain");
    chk("random_balance", 64'(n_rsp - r0), 64'(n_acc - a0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
